// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one shared single-digit BCD stage, LSD first,
// start/busy/done handshake with registered result held until the next completion.
module bcd_serial_add_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q;
  logic [W-1:0]    a_q, b_q, work_q;
  logic            c_q;
  logic            err_w_q;
  logic [IdxW-1:0] idx_q;

  logic [3:0]      a_dig, b_dig, dig;
  logic [4:0]      raw, adj;
  logic            c_nxt;
  logic [W-1:0]    work_d;
  logic            in_err;

  // Shared single-digit BCD stage operating on the latched operands.
  always_comb begin
    a_dig  = a_q[{idx_q, 2'b00} +: 4];
    b_dig  = b_q[{idx_q, 2'b00} +: 4];
    raw    = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, c_q};
    adj    = raw + 5'd6;
    if (raw > 5'd9) begin
      dig   = adj[3:0];
      c_nxt = 1'b1;
    end else begin
      dig   = raw[3:0];
      c_nxt = 1'b0;
    end
    work_d = work_q;
    work_d[{idx_q, 2'b00} +: 4] = dig;
  end

  // Invalid-digit flag over the operands being accepted this edge.
  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) in_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      c_q     <= 1'b0;
      err_w_q <= 1'b0;
      idx_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= cin;
            err_w_q <= in_err;
            work_q  <= '0;
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end else begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        StRun: begin
          work_q <= work_d;
          c_q    <= c_nxt;
          if (idx_q == LastIdx) begin
            sum     <= work_d;
            cout    <= c_nxt;
            err     <= err_w_q;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
- Sequencer that adds two DIGITS-digit packed-BCD operands with one shared single-digit BCD add stage (binary add plus +6 correction), one digit per clock, LSD first.
- Sits between a register/bus front end and BCD arithmetic consumers; trades latency for area against a fully parallel multi-digit BCD adder.
- Start/busy/done handshake; result and carry-out registered and held until the next operation completes.

Parameters:
- DIGITS, 4, number of BCD digits per operand (>=1); operand width 4*DIGITS.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0]
- b  input  4*DIGITS  operand B, packed BCD
- cin  input  1  carry into digit 0
- busy  output  1  high while digits are being processed
- done  output  1  one-cycle pulse: sum/cout/err just updated
- sum  output  4*DIGITS  registered BCD result
- cout  output  1  registered carry out of the most significant digit
- err  output  1  registered: some input digit of a or b was >9

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (clk, rst_n). Reset forces state IDLE and clears busy, done, sum, cout, err, digit index, working registers.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at an edge latches a, b, cin into working registers, index=0, goes to RUN. start=0 stays IDLE.
- RUN: busy=1. Each edge processes digit[index]:
  - raw = a_d + b_d + c, 5-bit, range 0..31.
  - If raw>9: digit=(raw+6) mod 16, c=1. Otherwise digit=raw[3:0], c=0.
  - The digit is written into the working sum. index increments.
  - On the edge processing index DIGITS-1: load sum, cout=c and err into the output registers, then go to DONE.
- DONE: done=1 for exactly this one cycle, busy=0.
  - start=1 at this edge re-latches and goes straight to RUN (back-to-back operation).
  - Otherwise goes to IDLE.
- Latency: start accepted at edge 0. Digits are processed at edges 1..DIGITS. done is high in the cycle after edge DIGITS. Next start is accepted at edge DIGITS+1. Throughput is one operation per DIGITS+1 cycles.
- start while in RUN is ignored. Input changes during RUN have no effect, because only the latched copies are used.
- err is computed from the latched operands at the start edge: OR over all 2*DIGITS digits of (digit>9). The computation still runs using the raw-value rule above. err is only meaningful when done is high, and it holds until the next completion.
- sum, cout and err change only at the transition into DONE; they hold their values in IDLE and RUN.
- Reset asserted mid-RUN aborts immediately: no done pulse, outputs cleared.
- DIGITS=1: RUN lasts one cycle.
- No wrap-around: index never exceeds DIGITS-1.

Test Plan:
- DIGITS=4. a=0x0999, b=0x0001, cin=0, start pulse -> done exactly 5 cycles after the start edge; sum=0x1000, cout=0, err=0; busy high for 4 cycles.
- a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1. Then a=0x4567, b=0x1234, cin=1, started in the DONE cycle -> sum=0x5802, cout=0, with no IDLE cycle between the two operations.
- a=0x00A5, b=0x0000 -> err=1. sum follows the raw rule: digit1 raw=10 -> digit 0x0 with carry 1, giving sum=0x0105 and cout=0.
- Start held high continuously: operations complete every 5 cycles. Toggling a/b during RUN does not change the result; an extra start during RUN is ignored.
- rst_n pulled low asynchronously between clock edges while in RUN -> busy, done, sum, cout, err read 0 immediately. After release, no done pulse appears until a new start is accepted.
- DIGITS=1 build: a=0x9, b=0x9, cin=1 -> sum=0x9, cout=1, done 2 cycles after the start edge.
